rr_arb_64b: RTL and testbench
=============================

Name: rr_arb_64b

Overview:
Round-robin arbiter for 64 requesters that shares a single downstream resource.
Built around two combinational pri_64b instances (masked and unmasked) to pick the next grantee; a small FSM sequences arbitration, grant hold and release.
Optional hold limit forces rotation so no requester starves others.
Grant is one-hot and registered; index output is provided for mux select.

Parameters:
MAX_HOLD, 16, max consecutive cycles a grant may be held; 0 = unlimited; legal range 0..65535
LOCK_EN, 1'b1, 1 = grant held while requester keeps req high; 0 = every grant lasts exactly one cycle

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
en_i  in  1  arbitration enable; gates new grants only
req_i  in  64  request vector, bit n = requester n
gnt_o  out  64  registered one-hot grant
gnt_vld_o  out  1  gnt_o nonzero
gnt_idx_o  out  6  binary index of granted requester; 0 when no grant
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (async): state=IDLE, gnt_o=0, gnt_vld_o=0, gnt_idx_o=0, busy_o=0, hold_cnt=0, mask=all ones (requester 0 highest first).
- Priority rule: pri_64b returns a one-hot of the lowest set index. sel = pri(req_i & mask) if that is nonzero, else pri(req_i).
- After a grant to index k: mask = bits strictly above k. k=63 gives mask=0, so the next pick wraps to the lowest requester.
- IDLE: gnt_o=0. If en_i && |req_i, go to ARB; otherwise stay.
- ARB: evaluate sel on the current req_i.
  - If sel!=0 && en_i: register gnt_o=sel and gnt_idx_o=idx(sel), set hold_cnt=1, go to GRANT.
  - If req_i==0 or en_i=0: go to IDLE with no grant.
- GRANT: gnt_o stable.
  - Release condition: req_i[idx]==0, OR (MAX_HOLD!=0 && hold_cnt==MAX_HOLD), OR LOCK_EN==0.
  - On release: next cycle gnt_o=0, mask updated from idx; go to ARB if en_i && |(req_i with bit idx cleared), else IDLE.
  - Otherwise: hold_cnt++ (saturating 16 b).
- Latency: req sampled in IDLE at edge 0 → ARB at edge 1 → gnt_o valid after edge 2. Exactly one bubble cycle (ARB, gnt_o=0) between consecutive grants.
- Forced rotation: a preempted requester still asserting req re-competes normally. It ranks after the others because mask excludes it.
- en_i deasserted in GRANT: no preemption; the current grant runs to release, then IDLE.
- Requests not in sel are ignored and need no hold.
- Requests appearing in the same cycle as a release are considered in the following ARB.
- busy_o = (state != IDLE); gnt_vld_o = |gnt_o.
- Reset mid-grant: outputs clear immediately (async); arbitration restarts with mask=all ones.

Decomposition:
- Package arb_pkg:
  - NREQ=64, IDX_W=6
  - arb_state_t enum {IDLE, ARB, GRANT}
  - function onehot2idx(64b) → 6b
  - function mask_above(6b) → 64b
- Sub-module: pri_64b, two instances, OUT_REG=1'b0, init_i tied 1'b1.
  - Masked-request input and raw-request input.
  - clk_i/rst_n_i connected but unused.
- No other sub-modules. Expected RTL roughly 150–220 lines.

Test Plan:
1. Single requester: req_i=1<<5 held 4 cycles, then 0 → gnt_o=1<<5 and gnt_idx_o=5 two cycles after req rises; held while req high; gnt_o=0 the cycle after req falls; FSM back to IDLE.
2. Rotation: MAX_HOLD=4, req_i bits {3,10,40} held constant → grant order 3,10,40,3,10; each grant 4 cycles; one gnt_o=0 cycle between grants.
3. Wrap-around: force last grant=63, then req_i bits {0,63} with bit 63 released → next grant index 0, not 63.
4. Enable drop: en_i→0 during a grant to 7 while req bits {7,9} stay high → grant 7 continues until req[7] falls (or hold limit), then IDLE; 9 is not granted until en_i→1.
5. Reset mid-grant: rst_n_i low while gnt_o=1<<12 → gnt_o=0 without a clock edge; after release req bits {1,2} → grant 1 first.
6. Vanishing request: req_i=1<<20 for 1 cycle only (drops in ARB) → no grant issued, gnt_vld_o stays 0, return to IDLE; with LOCK_EN=0, req bits {4,5} held → alternating single-cycle grants 4,5,4.

Source files
------------

// File: rtl/rr_arb_64b_pkg.sv
// Shared types and helpers for the 64-requester round-robin arbiter.
package arb_pkg;

    localparam int unsigned NREQ  = 64;
    localparam int unsigned IDX_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        GRANT
    } arb_state_t;

    // Binary index of a one-hot vector; 0 for an all-zero vector.
    function automatic logic [IDX_W-1:0] onehot2idx(input logic [NREQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Bits strictly above k; k = NREQ-1 yields all zeros.
    function automatic logic [NREQ-1:0] mask_above(input logic [IDX_W-1:0] k);
        logic [NREQ-1:0] m;
        m = {NREQ{1'b1}} << k;
        return m << 1;
    endfunction

endpackage

// File: rtl/rr_arb_64b_pri.sv
// Lowest-index-first priority picker: one-hot of the lowest set request bit.
module pri_64b
    import arb_pkg::*;
#(
    parameter logic OUT_REG = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            init_i,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] pri_o
);

    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    logic [NREQ-1:0] pri_c;
    logic [NREQ-1:0] pri_q;

    // Two's-complement isolate of the lowest set bit, gated by init_i.
    always_comb begin
        pri_c = '0;
        if (init_i) begin
            pri_c = req_i & (~req_i + ONE);
        end
    end

    // Optional output register; bypassed when OUT_REG is 0.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pri_q <= '0;
        end else begin
            pri_q <= pri_c;
        end
    end

    assign pri_o = OUT_REG ? pri_q : pri_c;

endmodule

// File: rtl/rr_arb_64b.sv
// Round-robin arbiter for 64 requesters with registered one-hot grant,
// optional grant lock and hold limit to force rotation.
module rr_arb_64b
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter logic        LOCK_EN  = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [NREQ-1:0]  req_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic             gnt_vld_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             busy_o
);

    localparam logic [15:0]     HOLD_LIM = 16'(MAX_HOLD);
    localparam logic            HOLD_EN  = (MAX_HOLD != 0);
    localparam logic [NREQ-1:0] ONE      = NREQ'(1);

    arb_state_t       state_q, state_d;
    logic [NREQ-1:0]  gnt_q,   gnt_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [15:0]      hold_q,  hold_d;
    logic [NREQ-1:0]  mask_q,  mask_d;

    logic [NREQ-1:0]  req_masked;
    logic [NREQ-1:0]  pri_mask;
    logic [NREQ-1:0]  pri_raw;
    logic [NREQ-1:0]  sel;
    logic [NREQ-1:0]  cur_bit;
    logic [NREQ-1:0]  req_others;
    logic             rel;

    assign req_masked = req_i & mask_q;

    pri_64b #(.OUT_REG(1'b0)) u_pri_mask (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .init_i  (1'b1),
        .req_i   (req_masked),
        .pri_o   (pri_mask)
    );

    pri_64b #(.OUT_REG(1'b0)) u_pri_raw (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .init_i  (1'b1),
        .req_i   (req_i),
        .pri_o   (pri_raw)
    );

    // Prefer requesters above the last grantee; wrap to the lowest otherwise.
    always_comb begin
        sel = pri_raw;
        if (|pri_mask) begin
            sel = pri_mask;
        end
    end

    // Release test for the current grant and the remaining competitors.
    always_comb begin
        cur_bit    = ONE << idx_q;
        req_others = req_i & ~cur_bit;
        rel        = !req_i[idx_q] || (HOLD_EN && (hold_q == HOLD_LIM)) || !LOCK_EN;
    end

    // Next-state and registered-output logic for the arbitration FSM.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        mask_d  = mask_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                idx_d = '0;
                if (en_i && |req_i) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (en_i && |sel) begin
                    gnt_d   = sel;
                    idx_d   = onehot2idx(sel);
                    hold_d  = 16'd1;
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (rel) begin
                    gnt_d   = '0;
                    idx_d   = '0;
                    hold_d  = '0;
                    mask_d  = mask_above(idx_q);
                    state_d = (en_i && |req_others) ? ARB : IDLE;
                end else if (hold_q != 16'hFFFF) begin
                    hold_d = hold_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            mask_q  <= '1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            mask_q  <= mask_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_idx_o = idx_q;
    assign gnt_vld_o = |gnt_q;
    assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_rr_arb_64b.sv
// Scoreboard bench for rr_arb_64b: three parameterisations share stimulus,
// a cycle-level reference model predicts outputs, a monitor compares them.
module tb_rr_arb_64b;

    localparam int NDUT = 3;
    localparam int M_IDLE = 0;
    localparam int M_ARB  = 1;
    localparam int M_GNT  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [63:0] req = '0;

    logic [63:0] gnt  [NDUT];
    logic [5:0]  idx  [NDUT];
    logic        vld  [NDUT];
    logic        busy [NDUT];

    int n_assert = 0;
    int n_fail   = 0;

    int unsigned mh_tab [NDUT] = '{4, 0, 0};
    bit          lk_tab [NDUT] = '{1'b1, 1'b0, 1'b1};

    typedef struct {
        int mode;
        int cur;
        int last;
        int hold;
    } mst_t;

    mst_t ms [NDUT];
    logic [NDUT-1:0][71:0] exp_q[$];
    logic [NDUT-1:0][71:0] exp_now;
    logic [NDUT-1:0][71:0] exp_chk;
    logic [71:0]           act;

    always #5 clk = ~clk;

    rr_arb_64b #(.MAX_HOLD(4), .LOCK_EN(1'b1)) u_dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .req_i(req),
        .gnt_o(gnt[0]), .gnt_vld_o(vld[0]), .gnt_idx_o(idx[0]), .busy_o(busy[0])
    );

    rr_arb_64b #(.MAX_HOLD(0), .LOCK_EN(1'b0)) u_dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .req_i(req),
        .gnt_o(gnt[1]), .gnt_vld_o(vld[1]), .gnt_idx_o(idx[1]), .busy_o(busy[1])
    );

    rr_arb_64b #(.MAX_HOLD(0), .LOCK_EN(1'b1)) u_dut_c (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .req_i(req),
        .gnt_o(gnt[2]), .gnt_vld_o(vld[2]), .gnt_idx_o(idx[2]), .busy_o(busy[2])
    );

    function automatic mst_t reset_state();
        mst_t s;
        s.mode = M_IDLE;
        s.cur  = -1;
        s.last = -1;
        s.hold = 0;
        return s;
    endfunction

    // Circular search starting just after the previous grantee.
    function automatic int pick(logic [63:0] r, int last);
        for (int off = 1; off <= 64; off++) begin
            if (r[(last + off) % 64]) return (last + off) % 64;
        end
        return -1;
    endfunction

    function automatic mst_t step(mst_t s, logic [63:0] r, logic e, int unsigned mh, bit lk);
        mst_t        n;
        bit          done;
        logic [63:0] rest;
        n = s;
        case (s.mode)
            M_IDLE: begin
                if (e && r != 0) n.mode = M_ARB;
            end
            M_ARB: begin
                if (e && r != 0) begin
                    n.cur  = pick(r, s.last);
                    n.hold = 1;
                    n.mode = M_GNT;
                end else begin
                    n.mode = M_IDLE;
                end
            end
            default: begin
                done = (r[s.cur] == 1'b0) || (mh != 0 && s.hold == int'(mh)) || !lk;
                if (done) begin
                    rest = r;
                    rest[s.cur] = 1'b0;
                    n.last = s.cur;
                    n.cur  = -1;
                    n.hold = 0;
                    n.mode = (e && rest != 0) ? M_ARB : M_IDLE;
                end else if (s.hold < 65535) begin
                    n.hold = s.hold + 1;
                end
            end
        endcase
        return n;
    endfunction

    function automatic logic [71:0] outputs_of(mst_t s);
        logic [63:0] g;
        logic [5:0]  i;
        g = '0;
        i = '0;
        if (s.cur >= 0) begin
            g = 64'd1 << s.cur;
            i = 6'(s.cur);
        end
        return {g, i, (s.cur >= 0), (s.mode != M_IDLE)};
    endfunction

    // Reference model: advance each model copy per clock and queue its prediction.
    always @(posedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            if (!rst_n) ms[k] = reset_state();
            else        ms[k] = step(ms[k], req, en, mh_tab[k], lk_tab[k]);
            exp_now[k] = outputs_of(ms[k]);
        end
        exp_q.push_back(exp_now);
    end

    // Monitor: pop one prediction per cycle and compare all three DUTs.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_chk = exp_q.pop_front();
            for (int k = 0; k < NDUT; k++) begin
                act = {gnt[k], idx[k], vld[k], busy[k]};
                n_assert++;
                if (act !== exp_chk[k]) begin
                    n_fail++;
                    $display("FAIL scoreboard dut%0d t=%0t: got gnt=%h idx=%0d vld=%b busy=%b, expected gnt=%h idx=%0d vld=%b busy=%b",
                             k, $time, act[71:8], act[7:2], act[1], act[0],
                             exp_chk[k][71:8], exp_chk[k][7:2], exp_chk[k][1], exp_chk[k][0]);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [63:0] bit_of(input int i);
        return 64'd1 << i;
    endfunction

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        for (int k = 0; k < NDUT; k++) ms[k] = reset_state();
        cyc(3);
        #2 rst_n = 1'b1;
        en = 1'b1;

        // Single requester
        cyc(1); req = bit_of(5);
        cyc(6); req = '0;
        cyc(4);

        // Rotation among three constant requesters
        req = bit_of(3) | bit_of(10) | bit_of(40);
        cyc(26); req = '0;
        cyc(4);

        // Wrap-around after a grant to 63
        req = bit_of(63);
        cyc(4); req = bit_of(0);
        cyc(4); req = '0;
        cyc(3);

        // Enable drop during a grant
        req = bit_of(7) | bit_of(9);
        cyc(3); en = 1'b0;
        cyc(6); req = bit_of(9);
        cyc(4); en = 1'b1;
        cyc(5); req = '0;
        cyc(3);

        // Asynchronous reset mid-grant
        req = bit_of(12);
        cyc(3);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            act = {gnt[k], idx[k], vld[k], busy[k]};
            n_assert++;
            if (act !== 72'd0) begin
                n_fail++;
                $display("FAIL async_reset dut%0d: got gnt=%h idx=%0d vld=%b busy=%b, expected all zero",
                         k, act[71:8], act[7:2], act[1], act[0]);
            end
        end
        cyc(1); req = bit_of(1) | bit_of(2);
        #2 rst_n = 1'b1;
        cyc(8); req = '0;
        cyc(3);

        // Vanishing request, then alternating single-cycle grants
        req = bit_of(20);
        cyc(1); req = '0;
        cyc(4); req = bit_of(4) | bit_of(5);
        cyc(8); req = '0;
        cyc(3);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 4))
                0: req = '0;
                1: req = bit_of(int'($urandom_range(0, 63)));
                2: req = bit_of(int'($urandom_range(0, 63))) | bit_of(int'($urandom_range(0, 63)))
                         | bit_of(int'($urandom_range(0, 63)));
                3: req = {$urandom, $urandom};
                default: req = req ^ bit_of(int'($urandom_range(0, 63))) ^ (($urandom_range(0, 1) != 0) ? bit_of(63) : bit_of(0));
            endcase
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 60) == 0) begin
                #2 rst_n = 1'b0;
                cyc(1);
                #2 rst_n = 1'b1;
            end
            cyc(int'($urandom_range(1, 10)));
        end

        req = '0;
        cyc(3);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
